mem_access_ctrl: RTL and testbench

- Initiator side of the 64x8 single-port synchronous data memory.
- Accepts 32-bit load/store requests from the core pipeline over a valid/ready handshake.
- Sequences each request into byte accesses on the memory port (wea/En/din/addr, 1-cycle registered dout).
- Assembles read bytes little-endian, sign/zero-extends loads, and returns a response over a valid/ready handshake.

---
 rtl/mem_access_ctrl_pkg.sv | 30 +++
 rtl/mem_access_ctrl_ext.sv | 24 ++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Size codes, FSM states and byte-count helper.
package mem_pkg;

    localparam int MEM_DEPTH = 64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } state_e;

    function automatic logic [2:0] bytes_of(input size_e sz);
        case (sz)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_ext.sv
// Load result extension: sign/zero-extends the assembled
// little-endian bytes from the top bit of the access size.
module mem_load_ext
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  size_e            size,
    input  logic             uns,
    input  logic [XLEN-1:0]  din,
    output logic [XLEN-1:0]  dout
);

    // extend from bit 8N-1
    always_comb begin
        dout = din;
        case (size)
            SZ_BYTE: dout = {{(XLEN-8){~uns & din[7]}}, din[7:0]};
            SZ_HALF: dout = {{(XLEN-16){~uns & din[15]}}, din[15:0]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial load/store initiator for the 64x8 data memory.
// MEM_MISALIGN_EN: allow misaligned half/word accesses (wrapping).
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_En,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);

    state_e            state_q;
    size_e             sz_q;
    logic              uns_q;
    logic [1:0]        cnt_q;
    logic [1:0]        last_q;
    logic [ADDR_W-1:0] base_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   asm_c;
    logic [XLEN-1:0]   ext_val;
    logic [1:0]        cnt_nx;
    logic [1:0]        cnt_pv;
    logic              mis;
    logic              bad;
    size_e             sz_in;

    assign sz_in  = size_e'(req_size);
    assign cnt_nx = cnt_q + 2'd1;
    assign cnt_pv = cnt_q - 2'd1;

`ifdef MEM_MISALIGN_EN
    assign mis = 1'b0;
`else
    assign mis = (sz_in == SZ_HALF && req_addr[0]) ||
                 (sz_in == SZ_WORD && req_addr[1:0] != 2'b00);
`endif

    assign bad = mis || (sz_in == SZ_ILL);

    // final byte arrives during DRAIN; merge it before extension
    always_comb begin
        asm_c = data_q;
        asm_c[{last_q, 3'b000} +: 8] = mem_dout;
    end

    mem_load_ext #(.XLEN(XLEN)) u_ext (
        .size (sz_q),
        .uns  (uns_q),
        .din  (asm_c),
        .dout (ext_val)
    );

    // request sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            sz_q       <= SZ_BYTE;
            uns_q      <= 1'b0;
            cnt_q      <= '0;
            last_q     <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_En     <= 1'b0;
            mem_wea    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        sz_q      <= sz_in;
                        uns_q     <= req_unsigned;
                        base_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt_q     <= '0;
                        last_q    <= 2'(bytes_of(sz_in) - 3'd1);
                        data_q    <= '0;
                        if (bad) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_En   <= 1'b1;
                            mem_wea  <= req_we;
                            mem_addr <= req_addr;
                            mem_din  <= req_we ? req_wdata[7:0] : 8'h00;
                            state_q  <= req_we ? WRITE : READ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt_q == last_q) begin
                        mem_En     <= 1'b0;
                        mem_wea    <= 1'b0;
                        mem_din    <= '0;
                        mem_addr   <= '0;
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q    <= cnt_nx;
                        mem_addr <= base_q + ADDR_W'(cnt_nx);
                        mem_din  <= wdata_q[{cnt_nx, 3'b000} +: 8];
                    end
                end
                READ: begin
                    if (cnt_q != 2'd0)
                        data_q[{cnt_pv, 3'b000} +: 8] <= mem_dout;
                    if (cnt_q == last_q) begin
                        mem_En   <= 1'b0;
                        mem_addr <= '0;
                        state_q  <= DRAIN;
                    end else begin
                        cnt_q    <= cnt_nx;
                        mem_addr <= base_q + ADDR_W'(cnt_nx);
                    end
                end
                DRAIN: begin
                    data_q     <= asm_c;
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_val;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 64x8 memory model.
// Table of requests plus hand sequences for stall and reset abort.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_En;
    logic        mem_wea;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    logic [7:0]  mem [64];

    int total = 0;
    int bad   = 0;

`ifdef MEM_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          en;
    } vec_t;

    vec_t tv [16];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .Rst_n        (Rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_En       (mem_En),
        .mem_wea      (mem_wea),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
        mem_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_En) begin
            if (mem_wea) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [5:0] a,
                         input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic wait_ready(input string nm);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check({nm, "_ready_to"}, 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output int lat, output int en);
        lat = 0;
        en  = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_En) en++;
            if (resp_valid) break;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input int k, input vec_t v);
        int lat;
        int en;
        string nm;
        nm = $sformatf("v%0d", k);
        @(negedge clk);
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        wait_ready(nm);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat, en);
        check({nm, "_lat"}, 32'(lat), 32'(v.lat));
        check({nm, "_en"}, 32'(en), 32'(v.en));
        check({nm, "_rdata"}, resp_rdata, v.rdata);
        check({nm, "_err"}, {31'd0, resp_err}, {31'd0, v.err});
        handshake();
    endtask

    initial begin
        int lat;
        int en;
        Rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_en_we", {30'd0, mem_En, mem_wea}, 32'd0);
        check("rst_data", resp_rdata, 32'd0);
        check("rst_misc", {17'd0, resp_err, mem_addr, mem_din}, 32'd0);
        Rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        tv[0]  = '{1'b1, 2'd2, 1'b0, 6'd8,  32'h11223344, 32'h0, 1'b0, 5, 4};
        tv[1]  = '{1'b0, 2'd2, 1'b0, 6'd8,  32'h0, 32'h11223344, 1'b0, 6, 4};
        tv[2]  = '{1'b0, 2'd1, 1'b1, 6'd10, 32'h0, 32'h00001122, 1'b0, 4, 2};
        tv[3]  = '{1'b0, 2'd0, 1'b0, 6'd20, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 1};
        tv[4]  = '{1'b0, 2'd0, 1'b1, 6'd20, 32'h0, 32'h000000FF, 1'b0, 3, 1};
        tv[5]  = '{1'b1, 2'd1, 1'b0, 6'd30, 32'h00008001, 32'h0, 1'b0, 3, 2};
        tv[6]  = '{1'b0, 2'd1, 1'b0, 6'd30, 32'h0, 32'hFFFF8001, 1'b0, 4, 2};
        tv[7]  = '{1'b0, 2'd0, 1'b1, 6'd31, 32'h0, 32'h00000080, 1'b0, 3, 1};
        tv[8]  = '{1'b0, 2'd0, 1'b0, 6'd31, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1};
        tv[9]  = '{1'b1, 2'd0, 1'b0, 6'd21, 32'hDEADBEA5, 32'h0, 1'b0, 2, 1};
        tv[10] = '{1'b0, 2'd2, 1'b0, 6'd20, 32'h0, 32'hFFFFA5FF, 1'b0, 6, 4};
        tv[11] = '{1'b0, 2'd3, 1'b0, 6'd0,  32'h0, 32'h0, 1'b1, 1, 0};
        tv[12] = MIS ? '{1'b0, 2'd1, 1'b0, 6'd31, 32'h0, 32'hFFFFFF80, 1'b0, 4, 2}
                     : '{1'b0, 2'd1, 1'b0, 6'd31, 32'h0, 32'h0, 1'b1, 1, 0};
        tv[13] = MIS ? '{1'b1, 2'd2, 1'b0, 6'd9, 32'h55667788, 32'h0, 1'b0, 5, 4}
                     : '{1'b1, 2'd2, 1'b0, 6'd9, 32'h55667788, 32'h0, 1'b1, 1, 0};
        tv[14] = MIS ? '{1'b1, 2'd2, 1'b0, 6'd62, 32'hAABBCCDD, 32'h0, 1'b0, 5, 4}
                     : '{1'b1, 2'd2, 1'b0, 6'd62, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0};
        tv[15] = MIS ? '{1'b0, 2'd2, 1'b1, 6'd62, 32'h0, 32'hAABBCCDD, 1'b0, 6, 4}
                     : '{1'b0, 2'd2, 1'b1, 6'd62, 32'h0, 32'h0, 1'b1, 1, 0};

        for (int k = 0; k < 16; k++) run(k, tv[k]);

        check("mem8", {24'd0, mem[8]}, 32'h44);
        check("mem9_11", {8'd0, mem[11], mem[10], mem[9]},
              MIS ? 32'h00667788 : 32'h00112233);
        check("mem62_63", {16'd0, mem[63], mem[62]},
              MIS ? 32'h0000CCDD : 32'h0000FFFF);
        check("mem0_1", {16'd0, mem[1], mem[0]},
              MIS ? 32'h0000AABB : 32'h0000FFFF);
        check("mem22", {24'd0, mem[22]}, 32'hFF);

        // stalled response with a second request waiting
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b1, 6'd20, 32'h0);
        wait_ready("a");
        @(posedge clk);
        #1 drive(1'b0, 2'd0, 1'b1, 6'd21, 32'h0);
        wait_resp(lat, en);
        check("a_lat", 32'(lat), 32'd6);
        check("a_rdata", resp_rdata, 32'hFFFFA5FF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("a_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("a_hold_rdata", resp_rdata, 32'hFFFFA5FF);
            check("a_hold_ready", {31'd0, req_ready}, 32'd0);
            check("a_hold_en", {31'd0, mem_En}, 32'd0);
        end
        handshake();
        @(negedge clk);
        check("a_idle_ready", {31'd0, req_ready}, 32'd1);
        check("a_no_early", {31'd0, mem_En}, 32'd0);
        @(negedge clk);
        check("a_acc_en", {31'd0, mem_En}, 32'd1);
        check("a_acc_addr", {26'd0, mem_addr}, 32'd21);
        req_valid = 1'b0;
        wait_resp(lat, en);
        check("a2_rdata", resp_rdata, 32'h000000A5);
        check("a2_valid", {31'd0, resp_valid}, 32'd1);
        handshake();

        // reset during third write cycle of a word store
        @(negedge clk);
        drive(1'b1, 2'd2, 1'b0, 6'd48, 32'hCAFEBABE);
        wait_ready("b");
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b_c3_en", {31'd0, mem_En}, 32'd1);
        check("b_c3_addr", {26'd0, mem_addr}, 32'd50);
        Rst_n = 1'b0;
        #1;
        check("b_async_en", {30'd0, mem_En, mem_wea}, 32'd0);
        @(negedge clk);
        check("b_rst_resp", {30'd0, resp_valid, req_ready}, 32'd0);
        Rst_n = 1'b1;
        @(negedge clk);
        check("b_rel_ready", {31'd0, req_ready}, 32'd1);
        check("b_rel_rvalid", {31'd0, resp_valid}, 32'd0);
        check("b_mem", {mem[51], mem[50], mem[49], mem[48]}, 32'hFFFFBABE);
        repeat (3) @(negedge clk);
        check("b_no_resp", {31'd0, resp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
